// File: rtl/icb_demux_if.sv
// ============================================================================
// Module  : icb_demux_if
// Brief   : ICB command/response bundle with master and slave views.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface icb_demux_if #(
    parameter int AW = 32
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_err;
    logic [31:0]   rsp_rdata;

    // Master issues commands and consumes responses.
    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

`default_nettype wire

// File: rtl/icb_demux.sv
// ============================================================================
// Module  : icb_demux
// Brief   : 1-to-3 ICB demux with address decode, internal error slave and an
//           in-order outstanding-target FIFO for response steering.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module icb_demux #(
    parameter int OUTS_DEPTH = 2,
    parameter int AW         = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    icb_demux_if.slave    m_icb,
    icb_demux_if.master   s0_icb,
    icb_demux_if.master   s1_icb,
    icb_demux_if.master   s2_icb
);

    localparam int PW = $clog2(OUTS_DEPTH);

    localparam logic [1:0] TGT_S0  = 2'd0;
    localparam logic [1:0] TGT_S1  = 2'd1;
    localparam logic [1:0] TGT_S2  = 2'd2;
    localparam logic [1:0] TGT_ERR = 2'd3;

    // ------------------------------------------------------------------
    // Slave-side signals gathered into vectors, bit K = slave K
    // ------------------------------------------------------------------
    logic [2:0]  slv_cmd_ready;
    logic [2:0]  slv_rsp_valid;
    logic [2:0]  slv_rsp_err;
    logic [31:0] slv_rsp_rdata [3];
    logic [2:0]  slv_cmd_valid;
    logic [2:0]  slv_rsp_ready;

    assign slv_cmd_ready    = {s2_icb.cmd_ready, s1_icb.cmd_ready, s0_icb.cmd_ready};
    assign slv_rsp_valid    = {s2_icb.rsp_valid, s1_icb.rsp_valid, s0_icb.rsp_valid};
    assign slv_rsp_err      = {s2_icb.rsp_err,   s1_icb.rsp_err,   s0_icb.rsp_err};
    assign slv_rsp_rdata[0] = s0_icb.rsp_rdata;
    assign slv_rsp_rdata[1] = s1_icb.rsp_rdata;
    assign slv_rsp_rdata[2] = s2_icb.rsp_rdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [3:0] region;
    logic [1:0] cmd_tgt;
    logic       tgt_ready;

    assign region  = m_icb.cmd_addr[AW-1:AW-4];
    assign cmd_tgt = (region > 4'd2) ? TGT_ERR : region[1:0];

    always_comb begin
        tgt_ready = 1'b1;
        case (cmd_tgt)
            TGT_S0:  tgt_ready = slv_cmd_ready[0];
            TGT_S1:  tgt_ready = slv_cmd_ready[1];
            TGT_S2:  tgt_ready = slv_cmd_ready[2];
            default: tgt_ready = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Outstanding-target FIFO
    // ------------------------------------------------------------------
    logic [PW:0] wptr_q, wptr_d;
    logic [PW:0] rptr_q, rptr_d;
    logic [1:0]  ids_q [OUTS_DEPTH];
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  head_tgt;
    logic        push;
    logic        pop;

    assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) &&
                        (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign fifo_empty = (wptr_q == rptr_q);
    assign head_tgt   = ids_q[rptr_q[PW-1:0]];

    // ------------------------------------------------------------------
    // Command path: full blocks acceptance regardless of a same-cycle pop,
    // so cmd_ready never depends combinationally on the response side.
    // ------------------------------------------------------------------
    logic cmd_ready;
    logic cmd_gate;

    assign cmd_gate  = rst_n & ~fifo_full;
    assign cmd_ready = cmd_gate & tgt_ready;
    assign push      = m_icb.cmd_valid & cmd_ready;

    always_comb begin
        slv_cmd_valid = 3'b000;
        if (cmd_gate && m_icb.cmd_valid && (cmd_tgt != TGT_ERR)) begin
            slv_cmd_valid[cmd_tgt] = 1'b1;
        end
    end

    assign m_icb.cmd_ready = cmd_ready;

    assign s0_icb.cmd_valid = slv_cmd_valid[0];
    assign s0_icb.cmd_addr  = m_icb.cmd_addr;
    assign s0_icb.cmd_read  = m_icb.cmd_read;
    assign s0_icb.cmd_wdata = m_icb.cmd_wdata;
    assign s0_icb.cmd_wmask = m_icb.cmd_wmask;

    assign s1_icb.cmd_valid = slv_cmd_valid[1];
    assign s1_icb.cmd_addr  = m_icb.cmd_addr;
    assign s1_icb.cmd_read  = m_icb.cmd_read;
    assign s1_icb.cmd_wdata = m_icb.cmd_wdata;
    assign s1_icb.cmd_wmask = m_icb.cmd_wmask;

    assign s2_icb.cmd_valid = slv_cmd_valid[2];
    assign s2_icb.cmd_addr  = m_icb.cmd_addr;
    assign s2_icb.cmd_read  = m_icb.cmd_read;
    assign s2_icb.cmd_wdata = m_icb.cmd_wdata;
    assign s2_icb.cmd_wmask = m_icb.cmd_wmask;

    // ------------------------------------------------------------------
    // Response path, steered by the FIFO head
    // ------------------------------------------------------------------
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    always_comb begin
        rsp_valid     = 1'b0;
        rsp_err       = 1'b0;
        rsp_rdata     = 32'h0000_0000;
        slv_rsp_ready = 3'b000;
        if (!fifo_empty) begin
            if (head_tgt == TGT_ERR) begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end else begin
                rsp_valid               = slv_rsp_valid[head_tgt];
                rsp_err                 = slv_rsp_err[head_tgt];
                rsp_rdata               = slv_rsp_rdata[head_tgt];
                slv_rsp_ready[head_tgt] = m_icb.rsp_ready;
            end
        end
    end

    assign pop = rsp_valid & m_icb.rsp_ready;

    assign m_icb.rsp_valid = rsp_valid;
    assign m_icb.rsp_err   = rsp_err;
    assign m_icb.rsp_rdata = rsp_rdata;

    assign s0_icb.rsp_ready = slv_rsp_ready[0];
    assign s1_icb.rsp_ready = slv_rsp_ready[1];
    assign s2_icb.rsp_ready = slv_rsp_ready[2];

    // ------------------------------------------------------------------
    // Pointer and storage registers
    // ------------------------------------------------------------------
    assign wptr_d = wptr_q + {{PW{1'b0}}, push};
    assign rptr_d = rptr_q + {{PW{1'b0}}, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Stored IDs are meaningless while empty, so they need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ids_q[wptr_q[PW-1:0]] <= cmd_tgt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icb_demux.sv
// ============================================================================
// Module  : tb_icb_demux
// Brief   : Directed plus randomized bench for icb_demux with a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icb_demux;

    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    icb_demux_if #(.AW(32)) m_if ();
    icb_demux_if #(.AW(32)) s0_if ();
    icb_demux_if #(.AW(32)) s1_if ();
    icb_demux_if #(.AW(32)) s2_if ();

    icb_demux #(.OUTS_DEPTH(DEPTH), .AW(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m_icb  (m_if),
        .s0_icb (s0_if),
        .s1_icb (s1_if),
        .s2_icb (s2_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit auto_mode = 1'b0;
    bit gen_en    = 1'b0;
    bit drain     = 1'b0;
    bit rst_en    = 1'b0;

    typedef struct { logic [1:0] tgt; logic [31:0] addr; } ent_t;
    typedef struct { int due; logic [31:0] addr; } sent_t;
    ent_t  q[$];
    sent_t sq [3][$];

    logic [2:0]  s_acc, s_fire;
    logic [31:0] s_acc_addr [3];
    logic        m_fire;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [1:0] decode(input logic [31:0] a);
        return (a[31:28] > 4'd2) ? 2'd3 : a[29:28];
    endfunction

    function automatic logic [31:0] rdf(input logic [31:0] a, input int k);
        return a ^ (32'h1357_9BDF * 32'(k + 1));
    endfunction

    function automatic logic errf(input logic [31:0] a, input int k);
        return a[2] ^ a[4] ^ (k == 1);
    endfunction

    task automatic drive_slave(input int k, input logic v, input logic e,
                               input logic [31:0] d, input logic rdy);
        case (k)
            0: begin s0_if.rsp_valid = v; s0_if.rsp_err = e; s0_if.rsp_rdata = d; s0_if.cmd_ready = rdy; end
            1: begin s1_if.rsp_valid = v; s1_if.rsp_err = e; s1_if.rsp_rdata = d; s1_if.cmd_ready = rdy; end
            default: begin s2_if.rsp_valid = v; s2_if.rsp_err = e; s2_if.rsp_rdata = d; s2_if.cmd_ready = rdy; end
        endcase
    endtask

    // ------------------------------------------------------------------
    // Cycle checker: expectations derived from the outstanding queue
    // ------------------------------------------------------------------
    initial forever begin
        logic        cv [3], cr [3], rv [3], rr [3], er [3];
        logic [31:0] rd [3], ad [3];
        logic [1:0]  tgt, head;
        logic        full, exp_cr, exp_rv, exp_err, tr;
        logic [31:0] exp_rd;
        @(negedge clk);
        cv = '{s0_if.cmd_valid, s1_if.cmd_valid, s2_if.cmd_valid};
        cr = '{s0_if.cmd_ready, s1_if.cmd_ready, s2_if.cmd_ready};
        rv = '{s0_if.rsp_valid, s1_if.rsp_valid, s2_if.rsp_valid};
        rr = '{s0_if.rsp_ready, s1_if.rsp_ready, s2_if.rsp_ready};
        er = '{s0_if.rsp_err,   s1_if.rsp_err,   s2_if.rsp_err};
        rd = '{s0_if.rsp_rdata, s1_if.rsp_rdata, s2_if.rsp_rdata};
        ad = '{s0_if.cmd_addr,  s1_if.cmd_addr,  s2_if.cmd_addr};
        if (!rst_n) q.delete();
        full = (q.size() >= DEPTH);
        tgt  = decode(m_if.cmd_addr);
        tr   = (tgt == 2'd3) ? 1'b1 : cr[tgt];
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s%0d_cmd_valid", k), 32'(cv[k]),
                32'(rst_n & m_if.cmd_valid & ~full & (tgt == 2'(k))));
            if (cv[k]) chk($sformatf("s%0d_cmd_addr", k), ad[k], m_if.cmd_addr);
        end
        exp_cr = ~full & tr;
        if (rst_n) chk("m_cmd_ready", 32'(m_if.cmd_ready), 32'(exp_cr));
        head    = (q.size() > 0) ? q[0].tgt : 2'd0;
        exp_rv  = (q.size() > 0) && ((head == 2'd3) || rv[head]);
        exp_err = 1'b1;
        exp_rd  = 32'h0;
        if (q.size() > 0 && head != 2'd3) begin
            exp_err = auto_mode ? errf(q[0].addr, int'(head)) : er[head];
            exp_rd  = auto_mode ? rdf(q[0].addr, int'(head)) : rd[head];
        end
        chk("m_rsp_valid", 32'(m_if.rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("m_rsp_err", 32'(m_if.rsp_err), 32'(exp_err));
            chk("m_rsp_rdata", m_if.rsp_rdata, exp_rd);
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("s%0d_rsp_ready", k), 32'(rr[k]),
                32'((q.size() > 0) && (head == 2'(k)) && m_if.rsp_ready));
        if (rst_n) begin
            ent_t e;
            if (exp_rv && m_if.rsp_ready) void'(q.pop_front());
            if (m_if.cmd_valid && exp_cr) begin
                e.tgt = tgt; e.addr = m_if.cmd_addr;
                q.push_back(e);
            end
        end
        for (int k = 0; k < 3; k++) begin
            s_acc[k]      = cv[k] & cr[k];
            s_fire[k]     = rv[k] & rr[k];
            s_acc_addr[k] = ad[k];
        end
        m_fire = m_if.cmd_valid & m_if.cmd_ready;
    end

    // ------------------------------------------------------------------
    // One clock of stimulus; in auto mode also runs the slave models
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_mode) begin
            for (int k = 0; k < 3; k++) begin
                sent_t se;
                if (s_fire[k]) void'(sq[k].pop_front());
                if (s_acc[k]) begin
                    se.due = cyc + int'($urandom_range(0, 4));
                    se.addr = s_acc_addr[k];
                    sq[k].push_back(se);
                end
            end
            if (rst_en && $urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                for (int k = 0; k < 3; k++) sq[k].delete();
            end else begin
                rst_n = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                logic v;
                v = (sq[k].size() > 0) && (sq[k][0].due <= cyc);
                drive_slave(k, v,
                            v ? errf(sq[k][0].addr, k) : 1'($urandom),
                            v ? rdf(sq[k][0].addr, k) : $urandom,
                            $urandom_range(0, 3) != 0);
            end
            m_if.rsp_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!rst_n) begin
                m_if.cmd_valid = 1'b0;
            end else if (!(m_if.cmd_valid && !m_fire)) begin
                logic [31:0] r;
                int n;
                n = int'($urandom_range(0, 7));
                r = $urandom;
                m_if.cmd_valid = gen_en && ($urandom_range(0, 9) < 7);
                m_if.cmd_addr  = {(n < 3) ? 4'(n) : 4'($urandom_range(3, 15)), r[27:2], 2'b00};
                m_if.cmd_read  = 1'($urandom);
                m_if.cmd_wdata = $urandom;
                m_if.cmd_wmask = 4'($urandom);
            end
        end
    endtask

    task automatic cmd(input logic v, input logic [31:0] a, input logic rd);
        m_if.cmd_valid = v;
        m_if.cmd_addr  = a;
        m_if.cmd_read  = rd;
        m_if.cmd_wdata = 32'hC0DE_0000 | a;
        m_if.cmd_wmask = 4'hF;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd(1'b1, 32'h0000_0000, 1'b1);
        m_if.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) drive_slave(k, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset holds outputs low even with a command presented
        @(negedge clk);
        @(negedge clk);
        chk("rst_s0_cmd_valid", 32'(s0_if.cmd_valid), 32'd0);
        chk("rst_rsp_valid", 32'(m_if.rsp_valid), 32'd0);
        step(); rst_n = 1'b1; cmd(1'b0, 32'h0, 1'b1);

        // Single read to s1
        step(); cmd(1'b1, 32'h1000_0004, 1'b1);
        @(negedge clk);
        chk("rd_s1_cmd_valid", 32'(s1_if.cmd_valid), 32'd1);
        chk("rd_cmd_ready", 32'(m_if.cmd_ready), 32'd1);
        step(); cmd(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("rd_s1_cmd_valid_once", 32'(s1_if.cmd_valid), 32'd0);
        chk("rd_no_early_rsp", 32'(m_if.rsp_valid), 32'd0);
        step(); drive_slave(1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        chk("rd_rsp_valid", 32'(m_if.rsp_valid), 32'd1);
        chk("rd_rsp_rdata", m_if.rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", 32'(m_if.rsp_err), 32'd0);
        step();
        @(negedge clk);
        chk("rd_empty_ignores_rsp", 32'(m_if.rsp_valid), 32'd0);
        chk("rd_empty_s1_rsp_ready", 32'(s1_if.rsp_ready), 32'd0);
        step(); drive_slave(1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Write to s2 then read from s0: s2 answers slower but goes first
        step(); cmd(1'b1, 32'h2000_0000, 1'b0);
        @(negedge clk);
        chk("ord_s2_cmd_valid", 32'(s2_if.cmd_valid), 32'd1);
        step(); cmd(1'b1, 32'h0000_0010, 1'b1);
        @(negedge clk);
        chk("ord_s0_cmd_valid", 32'(s0_if.cmd_valid), 32'd1);
        step(); cmd(1'b0, 32'h0, 1'b1); drive_slave(0, 1'b1, 1'b0, 32'h0000_1111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ord_s0_rsp_ready_blocked", 32'(s0_if.rsp_ready), 32'd0);
            chk("ord_no_rsp", 32'(m_if.rsp_valid), 32'd0);
            step();
        end
        drive_slave(2, 1'b1, 1'b0, 32'h2222_2222, 1'b1);
        @(negedge clk);
        chk("ord_first_rdata", m_if.rsp_rdata, 32'h2222_2222);
        chk("ord_s0_rsp_ready_still0", 32'(s0_if.rsp_ready), 32'd0);
        step(); drive_slave(2, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("ord_second_rdata", m_if.rsp_rdata, 32'h0000_1111);
        chk("ord_s0_rsp_ready", 32'(s0_if.rsp_ready), 32'd1);
        step(); drive_slave(0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Unmapped address goes to the error slave
        step(); cmd(1'b1, 32'h8000_0000, 1'b1);
        @(negedge clk);
        chk("err_cmd_ready", 32'(m_if.cmd_ready), 32'd1);
        chk("err_no_same_cycle_rsp", 32'(m_if.rsp_valid), 32'd0);
        step(); cmd(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("err_rsp_valid", 32'(m_if.rsp_valid), 32'd1);
        chk("err_rsp_err", 32'(m_if.rsp_err), 32'd1);
        chk("err_rsp_rdata", m_if.rsp_rdata, 32'h0);
        step();
        @(negedge clk);
        chk("err_popped", 32'(m_if.rsp_valid), 32'd0);

        // Full FIFO stalls the third command; response held while not ready
        step(); cmd(1'b1, 32'h0000_0100, 1'b1);
        step();
        step();
        @(negedge clk);
        chk("full_cmd_ready", 32'(m_if.cmd_ready), 32'd0);
        chk("full_s0_cmd_valid", 32'(s0_if.cmd_valid), 32'd0);
        step(); m_if.rsp_ready = 1'b0; drive_slave(0, 1'b1, 1'b0, 32'hAAAA_0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_rsp_rdata", m_if.rsp_rdata, 32'hAAAA_0001);
            chk("hold_s0_rsp_ready", 32'(s0_if.rsp_ready), 32'd0);
            step();
        end
        m_if.rsp_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_cmd_blocked", 32'(m_if.cmd_ready), 32'd0);
        chk("full_pop_s0_rsp_ready", 32'(s0_if.rsp_ready), 32'd1);
        step(); drive_slave(0, 1'b1, 1'b0, 32'hAAAA_0002, 1'b1);
        @(negedge clk);
        chk("pushpop_cmd_ready", 32'(m_if.cmd_ready), 32'd1);
        chk("pushpop_rdata", m_if.rsp_rdata, 32'hAAAA_0002);
        step(); cmd(1'b0, 32'h0, 1'b1); drive_slave(0, 1'b1, 1'b0, 32'hAAAA_0003, 1'b1);
        @(negedge clk);
        chk("third_rdata", m_if.rsp_rdata, 32'hAAAA_0003);
        step();
        @(negedge clk);
        chk("drained_rsp_valid", 32'(m_if.rsp_valid), 32'd0);
        step(); drive_slave(0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset with two outstanding commands
        m_if.rsp_ready = 1'b0;
        step(); cmd(1'b1, 32'h9000_0000, 1'b1);
        step(); cmd(1'b1, 32'h0000_0020, 1'b1);
        step(); cmd(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("pre_rst_rsp_valid", 32'(m_if.rsp_valid), 32'd1);
        step(); rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 32'(m_if.rsp_valid), 32'd0);
        step(); rst_n = 1'b1; m_if.rsp_ready = 1'b1;
        drive_slave(0, 1'b1, 1'b0, 32'h0BAD_0BAD, 1'b1);
        @(negedge clk);
        chk("post_rst_rsp_ignored", 32'(m_if.rsp_valid), 32'd0);
        chk("post_rst_s0_rsp_ready", 32'(s0_if.rsp_ready), 32'd0);
        step(); cmd(1'b1, 32'h1000_0100, 1'b1);
        @(negedge clk);
        chk("post_rst_s1_cmd_valid", 32'(s1_if.cmd_valid), 32'd1);
        step(); cmd(1'b0, 32'h0, 1'b1); drive_slave(1, 1'b1, 1'b0, 32'h5151_5151, 1'b1);
        @(negedge clk);
        chk("post_rst_rdata", m_if.rsp_rdata, 32'h5151_5151);
        chk("post_rst_s0_rsp_ready0", 32'(s0_if.rsp_ready), 32'd0);
        step(); drive_slave(0, 1'b0, 1'b0, 32'h0, 1'b1); drive_slave(1, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);

        // Randomized traffic against the queue model
        auto_mode = 1'b1;
        gen_en    = 1'b1;
        rst_en    = 1'b1;
        for (int i = 0; i < 4000; i++) step();
        gen_en = 1'b0;
        rst_en = 1'b0;
        drain  = 1'b1;
        for (int i = 0; i < 300 && q.size() > 0; i++) step();
        @(negedge clk);
        chk("drain_outstanding", 32'(q.size()), 32'd0);
        chk("drain_rsp_valid", 32'(m_if.rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icb_demux.md
ICB_DEMUX -- requirements
Module: icb_demux

Interface
REQ-001 Parameter OUTS_DEPTH, default 2: outstanding-transaction FIFO depth; power of 2, range 2..8.
REQ-002 Parameter AW, default 32: address width; address decoding uses bits [AW-1:AW-4].
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 m_icb_cmd_valid  input  1  master command valid, from the core system-control stage.
REQ-006 m_icb_cmd_ready  output  1  master command accepted.
REQ-007 m_icb_cmd_addr  input  AW  master word address; bits [1:0] are already 0.
REQ-008 m_icb_cmd_read  input  1  1 = read, 0 = write.
REQ-009 m_icb_cmd_wdata  input  32  write data.
REQ-010 m_icb_cmd_wmask  input  4  byte strobes.
REQ-011 m_icb_rsp_valid  output  1  response valid.
REQ-012 m_icb_rsp_ready  input  1  master ready to take the response.
REQ-013 m_icb_rsp_err  output  1  response error.
REQ-014 m_icb_rsp_rdata  output  32  read data.
REQ-015 sK_icb_cmd_valid/addr/read/wdata/wmask, K=0..2  output  1/AW/1/32/4  per-slave command; addr, read, wdata and wmask are broadcast unchanged.
REQ-016 sK_icb_cmd_ready, K=0..2  input  1  slave K accepts the command.
REQ-017 sK_icb_rsp_valid/err/rdata, K=0..2  input  1/1/32  slave K response.
REQ-018 sK_icb_rsp_ready, K=0..2  output  1  master is ready for slave K's response.

Function
REQ-019 Decode of addr[AW-1:AW-4]:
- 0x0 → target 0 (sK = s0)
- 0x1 → target 1 (s1)
- 0x2 → target 2 (s2)
- any other value → target 3, the internal error slave.
REQ-020 Outstanding FIFO: holds one 2-bit target ID per accepted command, in acceptance order, with at most OUTS_DEPTH entries.
REQ-021 Only the decoded slave sees sK_icb_cmd_valid = m_icb_cmd_valid & ~full; every other slave's cmd_valid is 0.
REQ-022 m_icb_cmd_ready = ~full & (ready of the decoded slave); the error slave's ready is always 1.
REQ-023 Push: on m_icb_cmd_valid & m_icb_cmd_ready, write the target ID into the FIFO and advance the write pointer.
REQ-024 When the FIFO is full, the command is blocked even if a pop happens in the same cycle; no combinational path from rsp to cmd_ready.
REQ-025 Response select: the target at the FIFO head drives the master response:
- m_icb_rsp_valid/err/rdata come from that slave.
- Only that slave's sK_icb_rsp_ready = m_icb_rsp_ready; all others are 0.
REQ-026 With the FIFO empty: m_icb_rsp_valid = 0 and every sK_icb_rsp_ready = 0. A slave response arriving in this state is ignored and stalls.
REQ-027 Error slave at the head: m_icb_rsp_valid = 1, err = 1, rdata = 0x0000_0000. Because the FIFO is registered, this response appears no earlier than the cycle after acceptance.
REQ-028 Pop: on m_icb_rsp_valid & m_icb_rsp_ready, advance the read pointer.
REQ-029 Push and pop in the same cycle when not full: both happen and the count is unchanged.
REQ-030 Pointers are log2(OUTS_DEPTH)+1 bits and wrap modulo 2*OUTS_DEPTH:
- full = MSBs differ and the remaining bits are equal.
- empty = the pointers are equal.
REQ-031 Write commands produce responses exactly like reads and are routed in the same way.
REQ-032 Response order to the master always equals command order, across slaves of different latency.

Reset
REQ-033 While rst_n = 0 (asynchronous assert, synchronous-safe release):
- FIFO pointers clear to 0, so the FIFO is empty and the stored IDs are don't-care.
- m_icb_rsp_valid = 0 and every sK_icb_cmd_valid = 0, regardless of other inputs.
REQ-034 A reset asserted mid-transaction discards all outstanding entries; responses from slaves that arrive after reset are ignored (REQ-026).

Verification
REQ-035 Read of addr 0x1000_0004, s1 ready, s1 responds 2 cycles later with rdata 0xDEAD_BEEF → s1_cmd_valid = 1 for one cycle; m_rsp_rdata = 0xDEAD_BEEF with err = 0; FIFO empty afterwards.
REQ-036 Write to 0x2000_0000 followed by a read of 0x0000_0010; s2 responds after 4 cycles, s0 after 1 cycle → the master sees s2's response first, then s0's; s0_rsp_ready stays 0 until s2's response is popped.
REQ-037 Read of 0x8000_0000 → cmd_ready = 1 in the same cycle; the next cycle m_rsp_valid = 1, err = 1, rdata = 0.
REQ-038 OUTS_DEPTH = 2, three back-to-back commands to s0, all slave rsp_valid held at 0 → the third command stalls with m_cmd_ready = 0 until the first response is popped.
REQ-039 m_rsp_ready = 0 for 3 cycles with s0's response valid → the response is held stable, no pop occurs, and s0_rsp_ready = 0 throughout.
REQ-040 rst_n pulsed low with 2 commands outstanding → m_rsp_valid = 0 immediately; a later s0_rsp_valid is not forwarded; the next new command is routed normally.
